sccb_cfg_seq: RTL and testbench

//  Camera register-init sequencer sitting directly upstream of the SCCB master.
//  It walks a table of {sub_addr, wdata} pairs held in an external synchronous ROM and issues one SCCB write per entry.

---
 rtl/sccb_cfg_seq.sv | 208 ++++++++++++++++++++
 tb/tb_sccb_cfg_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_seq.sv
// sccb_cfg_seq: camera register-init sequencer feeding an SCCB master.
// Walks a ROM of {sub_addr, wdata} pairs and issues one SCCB write per entry.
// With VERIFY set, reads each register back and counts mismatches.
// Entries with sub_addr 8'hFF are delay markers (no bus access).
module sccb_cfg_seq #(
    parameter int REG_NUM   = 58,
    parameter int AW        = 6,
    parameter int PWRUP_DLY = 25000,
    parameter int DLY_CYC   = 250000,
    parameter bit VERIFY    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    input  logic          rdy,
    output logic          wen,
    output logic          ren,
    output logic [7:0]    sub_addr,
    output logic [7:0]    wdata,
    input  logic [7:0]    rdata,
    input  logic          rdata_vld,
    output logic          busy,
    output logic          cfg_done,
    output logic          cfg_err,
    output logic [7:0]    err_cnt
);

    localparam int MAXD   = (PWRUP_DLY > DLY_CYC) ? PWRUP_DLY : DLY_CYC;
    localparam int CW_RAW = $clog2(MAXD + 1);
    localparam int CW     = (CW_RAW < 3) ? 3 : CW_RAW;

    localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_DLY - 1);
    localparam logic [CW-1:0] DLY_LAST   = CW'(DLY_CYC - 1);
    localparam logic [CW-1:0] WRB_LAST   = CW'(3);
    localparam logic [AW-1:0] IDX_LAST   = AW'(REG_NUM - 1);

    typedef enum logic [3:0] {
        IDLE,
        PWRUP,
        FETCH,
        LATCH,
        CHECK,
        WR_REQ,
        WR_BUSY,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        RD_END,
        DELAY,
        NEXT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx;
    logic          wen_r;
    logic          ren_r;

    // Request pulses are registered; masking with rst keeps the bus quiet
    // during the reset cycle even if a pulse was already scheduled.
    assign wen = wen_r & ~rst;
    assign ren = ren_r & ~rst;

    // Sequencer FSM: every transition clears the shared delay counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            rom_addr <= '0;
            sub_addr <= '0;
            wdata    <= '0;
            wen_r    <= 1'b0;
            ren_r    <= 1'b0;
            busy     <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            wen_r <= 1'b0;
            ren_r <= 1'b0;
            cnt   <= cnt + 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= PWRUP;
                        cnt      <= '0;
                        idx      <= '0;
                        cfg_err  <= 1'b0;
                        err_cnt  <= '0;
                        busy     <= 1'b1;
                        cfg_done <= 1'b0;
                    end
                end

                PWRUP: begin
                    if (cnt == PWRUP_LAST) begin
                        state    <= FETCH;
                        cnt      <= '0;
                        rom_addr <= idx;
                    end
                end

                FETCH: begin
                    state <= LATCH;
                    cnt   <= '0;
                end

                LATCH: begin
                    sub_addr <= rom_data[15:8];
                    wdata    <= rom_data[7:0];
                    state    <= CHECK;
                    cnt      <= '0;
                end

                CHECK: begin
                    state <= (sub_addr == 8'hFF) ? DELAY : WR_REQ;
                    cnt   <= '0;
                end

                WR_REQ: begin
                    if (rdy) begin
                        wen_r <= 1'b1;
                        state <= WR_BUSY;
                        cnt   <= '0;
                    end
                end

                WR_BUSY: begin
                    if (!rdy || cnt == WRB_LAST) begin
                        state <= WR_WAIT;
                        cnt   <= '0;
                    end
                end

                WR_WAIT: begin
                    if (rdy) begin
                        if (!VERIFY || {sub_addr, wdata} == 16'h1280) begin
                            state <= NEXT;
                        end else begin
                            state <= RD_REQ;
                        end
                        cnt <= '0;
                    end
                end

                RD_REQ: begin
                    if (rdy) begin
                        ren_r <= 1'b1;
                        state <= RD_WAIT;
                        cnt   <= '0;
                    end
                end

                RD_WAIT: begin
                    if (rdata_vld) begin
                        if (rdata != wdata) begin
                            cfg_err <= 1'b1;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                        end
                        state <= RD_END;
                        cnt   <= '0;
                    end
                end

                RD_END: begin
                    if (rdy) begin
                        state <= NEXT;
                        cnt   <= '0;
                    end
                end

                DELAY: begin
                    if (cnt == DLY_LAST) begin
                        state <= NEXT;
                        cnt   <= '0;
                    end
                end

                NEXT: begin
                    cnt <= '0;
                    if (idx == IDX_LAST) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        cfg_done <= 1'b1;
                    end else begin
                        idx      <= idx + 1'b1;
                        rom_addr <= idx + 1'b1;
                        state    <= FETCH;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// tb_sccb_cfg_seq: directed bench for the SCCB register-init sequencer.
module tb_sccb_cfg_seq;

    localparam int REG_NUM = 3;
    localparam int AW      = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data = '0;
    logic          rdy;
    logic          wen;
    logic          ren;
    logic [7:0]    sub_addr;
    logic [7:0]    wdata;
    logic [7:0]    rdata = '0;
    logic          rdata_vld = 1'b0;
    logic          busy;
    logic          cfg_done;
    logic          cfg_err;
    logic [7:0]    err_cnt;

    sccb_cfg_seq #(
        .REG_NUM  (REG_NUM),
        .AW       (AW),
        .PWRUP_DLY(10),
        .DLY_CYC  (50),
        .VERIFY   (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rdy      (rdy),
        .wen      (wen),
        .ren      (ren),
        .sub_addr (sub_addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rdata_vld(rdata_vld),
        .busy     (busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model
    logic [15:0] rom_img [0:3];
    always @(posedge clk) rom_data <= rom_img[rom_addr];

    // Behavioural SCCB master: rdy drops 1 cycle after a request, back 100 cycles later
    logic       rdy_m = 1'b1;
    logic       hold_low = 1'b0;
    logic       corrupt = 1'b0;
    int         mcnt = 0;
    logic       rd_pend = 1'b0;
    logic [7:0] rd_addr = '0;
    logic [7:0] mem [0:255];

    assign rdy = rdy_m && !hold_low;

    always @(posedge clk) begin
        rdata_vld <= 1'b0;
        if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 2 && rd_pend) begin
                rdata     <= (corrupt && rd_addr == 8'h7D) ? 8'h00 : mem[rd_addr];
                rdata_vld <= 1'b1;
                rd_pend   <= 1'b0;
            end
            if (mcnt == 1) rdy_m <= 1'b1;
        end else if (wen) begin
            mem[sub_addr] <= wdata;
            rdy_m <= 1'b0;
            mcnt  <= 100;
        end else if (ren) begin
            rd_pend <= 1'b1;
            rd_addr <= sub_addr;
            rdy_m   <= 1'b0;
            mcnt    <= 100;
        end
    end

    // Cycle counter and bus monitor (transaction log + protocol violations)
    int         cyc = 0;
    int         nlog = 0;
    int         viol = 0;
    logic [1:0] log_kind [0:63];
    logic [7:0] log_addr [0:63];
    logic [7:0] log_data [0:63];
    int         log_cyc  [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ((wen || ren) && (!rdy || rst)) viol = viol + 1;
        if (wen && ren) viol = viol + 1;
        if (wen && nlog < 64) begin
            log_kind[nlog] = 2'd1;
            log_addr[nlog] = sub_addr;
            log_data[nlog] = wdata;
            log_cyc[nlog]  = cyc;
            nlog = nlog + 1;
        end
        if (ren && nlog < 64) begin
            log_kind[nlog] = 2'd2;
            log_addr[nlog] = sub_addr;
            log_data[nlog] = 8'h00;
            log_cyc[nlog]  = cyc;
            nlog = nlog + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cfg_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Expected bus traffic derived from the ROM image: a write per non-marker
    // entry, followed by a read of the same register unless it is 12/80.
    task automatic check_log(input int base, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input string tag);
        logic [15:0] ents [3];
        logic [17:0] exp_t [8];
        int n;
        ents[0] = e0;
        ents[1] = e1;
        ents[2] = e2;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (ents[i][15:8] != 8'hFF) begin
                exp_t[n] = {2'd1, ents[i]};
                n++;
                if (ents[i] != 16'h1280) begin
                    exp_t[n] = {2'd2, ents[i][15:8], 8'h00};
                    n++;
                end
            end
        end
        check({tag, "_txn_count"}, 32'(nlog - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < nlog) begin
                check($sformatf("%s_txn%0d", tag, i),
                      {14'd0, log_kind[base+i], log_addr[base+i], log_data[base+i]},
                      {14'd0, exp_t[i]});
            end
        end
    endtask

    typedef struct {
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] r2;
        bit          corrupt;
        bit          mid_start;
        logic        exp_err;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [4];

    initial begin
        bit ok;
        int base;
        int rel_cyc;

        vecs[0] = '{16'h5A4C, 16'h7D01, 16'h1103, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[1] = '{16'h5A4C, 16'h7D01, 16'h1103, 1'b1, 1'b0, 1'b1, 8'd1};
        vecs[2] = '{16'h5A4C, 16'h7D01, 16'h1103, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3] = '{16'h1280, 16'hFF00, 16'h1200, 1'b0, 1'b0, 1'b0, 8'd0};

        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) rom_img[i] = 16'h0000;
        repeat (3) tick();
        check("reset_outputs",
              {8'd0, wen, ren, busy, cfg_done, cfg_err, err_cnt, rom_addr, sub_addr, wdata}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_no_busy", {30'd0, busy, cfg_done}, 32'd0);

        // Table-driven full runs
        for (int v = 0; v < 4; v++) begin
            rom_img[0] = vecs[v].r0;
            rom_img[1] = vecs[v].r1;
            rom_img[2] = vecs[v].r2;
            corrupt = vecs[v].corrupt;
            base = nlog;
            pulse_start();
            check($sformatf("v%0d_start_state", v), {20'd0, busy, cfg_done, cfg_err, err_cnt, 1'b0},
                  {20'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0});
            if (vecs[v].mid_start) begin
                repeat (5) tick();
                pulse_start();
                repeat (40) tick();
                pulse_start();
            end
            wait_done(3000, ok);
            check($sformatf("v%0d_done_reached", v), 32'(ok), 32'd1);
            tick();
            check($sformatf("v%0d_final", v), {21'd0, busy, cfg_done, cfg_err, err_cnt},
                  {21'd0, 1'b0, 1'b1, vecs[v].exp_err, vecs[v].exp_cnt});
            check_log(base, vecs[v].r0, vecs[v].r1, vecs[v].r2, $sformatf("v%0d", v));
            if (vecs[v].r1[15:8] == 8'hFF && nlog >= base + 2) begin
                check("delay_gap_ok", 32'((log_cyc[base+1] - log_cyc[base]) >= 150), 32'd1);
            end
        end

        // rdy held low before the first write
        rom_img[0] = 16'h5A4C;
        rom_img[1] = 16'h7D01;
        rom_img[2] = 16'h1103;
        corrupt = 1'b0;
        base = nlog;
        hold_low = 1'b1;
        pulse_start();
        repeat (300) tick();
        check("rdy_low_no_wen", 32'(nlog - base), 32'd0);
        rel_cyc = cyc;
        hold_low = 1'b0;
        wait_done(3000, ok);
        check("rdy_low_done", 32'(ok), 32'd1);
        if (nlog > base) check("rdy_low_wen_after_rise", 32'(log_cyc[base] >= rel_cyc), 32'd1);
        check_log(base, 16'h5A4C, 16'h7D01, 16'h1103, "rdy_low");

        // Reset during the second write's WR_WAIT, then restart from entry 0
        base = nlog;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (nlog >= base + 3) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("second_write_seen", 32'(ok), 32'd1);
        repeat (20) tick();
        check("second_write_pending", 32'(nlog - base), 32'd3);
        rst = 1'b1;
        tick();
        check("mid_reset_outputs",
              {8'd0, wen, ren, busy, cfg_done, cfg_err, err_cnt, rom_addr, sub_addr, wdata}, 32'd0);
        rst = 1'b0;
        tick();
        base = nlog;
        pulse_start();
        wait_done(3000, ok);
        check("restart_done", 32'(ok), 32'd1);
        check_log(base, 16'h5A4C, 16'h7D01, 16'h1103, "restart");

        check("protocol_violations", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
